// File: rtl/ifetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [5:0] OPC_B       = 6'b000101;
  localparam int         INSTR_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Unconditional-branch target: imm26 is a word offset relative to the B itself.
  function automatic logic [63:0] b_target(input logic [63:0] pc, input logic [25:0] imm26);
    return pc + {{36{imm26[25]}}, imm26, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue.sv
// FIFO of fetched {pc, instr} entries; head is presented directly from storage.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  entry_t        i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output entry_t        o_head,
  output logic          o_valid,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_head  = r_mem[r_rd];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, single-outstanding instruction-memory initiator and redirect handling.
// Optional B predecode is enabled by defining IFETCH_PREDECODE_B_EN.
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        MemReq,
  output logic [63:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [63:0] RedirectPC,
  output state_t      o_dbg_state
);

  localparam int            CW    = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  state_t        r_state;
  logic [63:0]   r_pc;
  logic [63:0]   r_mem_addr;
  logic          r_mem_req;

  state_t        w_next_state;
  logic [63:0]   w_next_pc;
  logic [63:0]   w_seq_pc;
  entry_t        w_head;
  logic          w_qvalid;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  logic          w_space;
  logic          w_pop;
  logic          w_push;

  // Handshake: a word moves to decode on any rising edge where InstrValid && InstrReady.
  assign w_pop  = w_qvalid && InstrReady;
  assign w_push = (r_state == REQ) && MemAck && !Redirect;

  always_comb begin
    w_count_after = w_count;
    if (w_push && !w_pop)      w_count_after = w_count + CW'(1);
    else if (!w_push && w_pop) w_count_after = w_count - CW'(1);
  end

  // With at most one request outstanding, space means the queue is not full after this cycle.
  assign w_space = (w_count_after < QFULL);

`ifdef IFETCH_PREDECODE_B_EN
  assign w_seq_pc = (MemData[31:26] == OPC_B) ? b_target(r_pc, MemData[25:0])
                                              : r_pc + 64'(INSTR_BYTES);
`else
  assign w_seq_pc = r_pc + 64'(INSTR_BYTES);
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    if (Redirect) begin
      w_next_pc = RedirectPC & ~64'h3;
      if ((r_state != IDLE) && !MemAck) w_next_state = DRAIN;
      else                              w_next_state = REQ;
    end else begin
      case (r_state)
        IDLE: if (w_space) w_next_state = REQ;
        REQ: begin
          if (MemAck) begin
            w_next_pc    = w_seq_pc;
            w_next_state = w_space ? REQ : IDLE;
          end
        end
        DRAIN: if (MemAck) w_next_state = REQ;
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_mem_addr <= RESET_PC;
      r_mem_req  <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_mem_req <= (w_next_state != IDLE);
      // A squashed request keeps its address on the bus until memory answers it.
      if (w_next_state != DRAIN) r_mem_addr <= w_next_pc;
    end
  end

  ifetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .i_clk   (CLK),
    .i_reset (Reset),
    .i_push  (w_push),
    .i_data  ('{pc: r_pc, instr: MemData}),
    .i_pop   (w_pop),
    .i_flush (Redirect),
    .o_head  (w_head),
    .o_valid (w_qvalid),
    .o_count (w_count)
  );

  assign MemReq      = r_mem_req;
  assign MemAddr     = r_mem_addr;
  assign InstrValid  = w_qvalid;
  assign Instr       = w_head.instr;
  assign InstrPC     = w_head.pc;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model, scoreboard of expected fetch stream.
module tb_instruction_fetch_unit;
  import ifetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          QDEPTH   = 2;

  logic        CLK        = 1'b0;
  logic        Reset      = 1'b1;
  logic        MemReq;
  logic [63:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrReady = 1'b0;
  logic        Redirect   = 1'b0;
  logic [63:0] RedirectPC = 64'h0;
  state_t      dbg_state;

  int n_tests   = 0;
  int n_fail    = 0;
  int lat       = 0;
  int r_wait    = 0;
  int deliv_cnt = 0;
  logic [95:0] exp_q[$];

  instruction_fetch_unit #(
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .MemReq      (MemReq),
    .MemAddr     (MemAddr),
    .MemAck      (MemAck),
    .MemData     (MemData),
    .InstrValid  (InstrValid),
    .Instr       (Instr),
    .InstrPC     (InstrPC),
    .InstrReady  (InstrReady),
    .Redirect    (Redirect),
    .RedirectPC  (RedirectPC),
    .o_dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84003E9;
      64'h4:   return 32'hF84083EA;
      64'h28:  return 32'h17FFFFFD;
      default: return {16'h8B00, a[17:2]};
    endcase
  endfunction

  function automatic logic [63:0] model_next(input logic [63:0] pc);
    logic [31:0] w;
    w = mem_word(pc);
`ifdef IFETCH_PREDECODE_B_EN
    if (w[31:26] == 6'b000101) return pc + {{36{w[25]}}, w[25:0], 2'b00};
`endif
    return pc + 64'd4;
  endfunction

  assign MemData = mem_word(MemAddr);
  assign MemAck  = MemReq && (r_wait >= lat);

  always @(posedge CLK) begin
    if (!MemReq || MemAck) r_wait <= 0;
    else                   r_wait <= r_wait + 1;
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the head of the expected stream.
  always @(negedge CLK) begin
    logic [95:0] e;
    if (!Reset && InstrValid && InstrReady) begin
      deliv_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", InstrPC, e[95:32]);
        check_eq("sb_instr", {32'h0, Instr}, {32'h0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic restart(input logic [63:0] pc);
    logic [63:0] p;
    exp_q.delete();
    p = pc & ~64'h3;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back({p, mem_word(p)});
      p = model_next(p);
    end
  endtask

  // Called at posedge+1; Redirect is seen at the next rising edge.
  task automatic do_redirect(input logic [63:0] pc);
    Redirect   = 1'b1;
    RedirectPC = pc;
    step(1);
    Redirect   = 1'b0;
    restart(pc);
  endtask

  task automatic wait_req_pending(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (MemReq && !MemAck) begin
        got = 1'b1;
        break;
      end
      step(1);
    end
    check_eq(tag, {63'h0, got}, 64'd1);
  endtask

  task automatic reset_check();
    Reset = 1'b1;
    step(1);
    check_eq("rst_memreq", {63'h0, MemReq}, 64'd0);
    check_eq("rst_valid", {63'h0, InstrValid}, 64'd0);
    check_eq("rst_addr", MemAddr, RESET_PC);
    check_eq("rst_state", 64'(dbg_state), 64'(IDLE));
    Reset = 1'b0;
    restart(RESET_PC);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   d0;
    logic got;

    restart(RESET_PC);
    step(3);
    check_eq("reset_memreq", {63'h0, MemReq}, 64'd0);
    check_eq("reset_valid", {63'h0, InstrValid}, 64'd0);
    check_eq("reset_addr", MemAddr, RESET_PC);
    check_eq("reset_state", 64'(dbg_state), 64'(IDLE));

    // 1: zero-latency memory, decode always ready -> one word per cycle
    InstrReady = 1'b1;
    Reset      = 1'b0;
    step(4);
    d0 = deliv_cnt;
    step(8);
    check_eq("t1_rate", 64'(deliv_cnt - d0), 64'd8);

    // 2: stall decode, queue fills and fetch stops, head holds
    InstrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_eq("t2_hold_valid", {63'h0, InstrValid}, 64'd1);
      check_eq("t2_hold_pc", InstrPC, exp_q[0][95:32]);
    end
    check_eq("t2_memreq_off", {63'h0, MemReq}, 64'd0);
    InstrReady = 1'b1;
    d0 = deliv_cnt;
    step(6);
    check_eq("t2_release", 64'(deliv_cnt - d0), 64'd6);

    // 3: slow memory, redirect while a request is waiting
    lat = 3;
    wait_req_pending("t3_pending");
    do_redirect(64'h1C);
    check_eq("t3_drain", 64'(dbg_state), 64'(DRAIN));
    check_eq("t3_drain_req", {63'h0, MemReq}, 64'd1);
    check_eq("t3_flushed", {63'h0, InstrValid}, 64'd0);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (dbg_state != DRAIN) begin
        got = 1'b1;
        break;
      end
      step(1);
    end
    check_eq("t3_drain_end", {63'h0, got}, 64'd1);
    check_eq("t3_state_req", 64'(dbg_state), 64'(REQ));
    check_eq("t3_new_addr", MemAddr, 64'h1C);
    step(12);
    lat = 0;
    step(4);

    // 4: misaligned redirect and address wrap
    do_redirect(64'h2E);
    check_eq("t4_align", MemAddr, 64'h2C);
    step(3);
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("t4_top", MemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1);
    check_eq("t4_wrap", MemAddr, 64'h0);
    step(4);

    // 5: B word at 0x28
    do_redirect(64'h28);
    check_eq("t5_b_addr", MemAddr, 64'h28);
    step(1);
`ifdef IFETCH_PREDECODE_B_EN
    check_eq("t5_after_b", MemAddr, 64'h1C);
`else
    check_eq("t5_after_b", MemAddr, 64'h2C);
`endif
    step(6);

    // 6: reset from a full queue, then reset from DRAIN
    InstrReady = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!MemReq) begin
        got = 1'b1;
        break;
      end
      step(1);
    end
    check_eq("t6_full_stop", {63'h0, got}, 64'd1);
    check_eq("t6_full_valid", {63'h0, InstrValid}, 64'd1);
    reset_check();
    lat = 3;
    wait_req_pending("t6_pending");
    do_redirect(64'h40);
    check_eq("t6_drain", 64'(dbg_state), 64'(DRAIN));
    reset_check();
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
